// File: rtl/twiddle_addr_gen_pkg.sv
// Shared FFT package: twiddle-select encoding used between the address
// generator and the quarter-table twiddle converter, plus multiplier pipeline depth.
package twiddle_addr_gen_pkg;

  localparam logic [1:0] SEL_W0 = 2'd0;
  localparam logic [1:0] SEL_W2 = 2'd1;
  localparam logic [1:0] SEL_W1 = 2'd2;
  localparam logic [1:0] SEL_W3 = 2'd3;

  function automatic int unsigned tw_pipe_latency();
    return 2;
  endfunction

endpackage

// File: rtl/twiddle_index_counter.sv
// Sample index counter for one LOG_M-point sub-transform; sync forces the
// current sample to index 0 and restarts the count from there.
module twiddle_index_counter #(
  parameter int LOG_M = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en_i,
  input  logic             sync_i,
  output logic [LOG_M-1:0] idx_o,
  output logic             first_o,
  output logic             last_o
);

  logic [LOG_M-1:0] n_q;
  logic [LOG_M-1:0] n_d;
  logic [LOG_M-1:0] idx;

  assign idx = sync_i ? '0 : n_q;

  // Natural LOG_M-bit wrap gives M-1 -> 0 with no idle cycle.
  always_comb begin
    n_d = n_q;
    if (en_i) begin
      n_d = idx + {{(LOG_M-1){1'b0}}, 1'b1};
    end else if (sync_i) begin
      n_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      n_q <= '0;
    end else begin
      n_q <= n_d;
    end
  end

  assign idx_o   = idx;
  assign first_o = (idx == '0);
  assign last_o  = &idx;

endmodule

// File: rtl/twiddle_addr_gen.sv
// Twiddle-number sequencer for the R2^2 SDF inter-stage multiplier: turns the
// sample index into W_N^k, k = num * sel, through a fixed 2-stage pipeline.
module twiddle_addr_gen
  import twiddle_addr_gen_pkg::*;
#(
  parameter int LOG_N = 6,
  parameter int LOG_M = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             di_en,
  input  logic             sync,
  output logic             tw_en,
  output logic [LOG_N-1:0] tw_addr,
  output logic             tw_unity,
  output logic             tw_first,
  output logic             tw_last
);

  logic [LOG_M-1:0] idx;
  logic             idx_first;
  logic             idx_last;
  logic [1:0]       sel;
  logic [LOG_N-1:0] num;

  twiddle_index_counter #(.LOG_M(LOG_M)) u_index_counter (
    .clock   (clock),
    .reset   (reset),
    .en_i    (di_en),
    .sync_i  (sync),
    .idx_o   (idx),
    .first_o (idx_first),
    .last_o  (idx_last)
  );

  // Top two index bits swapped give the quadrant multiplier 0,2,1,3.
  assign sel = {idx[LOG_M-2], idx[LOG_M-1]};

  generate
    if (LOG_M > 2) begin : g_num
      assign num = {{(LOG_N-LOG_M+2){1'b0}}, idx[LOG_M-3:0]} << (LOG_N-LOG_M);
    end else begin : g_num_zero
      assign num = '0;
    end
  endgenerate

  logic             s1_en_q,    s1_en_d;
  logic [LOG_N-1:0] s1_num_q,   s1_num_d;
  logic [1:0]       s1_sel_q,   s1_sel_d;
  logic             s1_first_q, s1_first_d;
  logic             s1_last_q,  s1_last_d;

  always_comb begin
    s1_en_d    = di_en;
    s1_num_d   = s1_num_q;
    s1_sel_d   = s1_sel_q;
    s1_first_d = s1_first_q;
    s1_last_d  = s1_last_q;
    if (di_en) begin
      s1_num_d   = num;
      s1_sel_d   = sel;
      s1_first_d = idx_first;
      s1_last_d  = idx_last;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_en_q    <= 1'b0;
      s1_num_q   <= '0;
      s1_sel_q   <= '0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
    end else begin
      s1_en_q    <= s1_en_d;
      s1_num_q   <= s1_num_d;
      s1_sel_q   <= s1_sel_d;
      s1_first_q <= s1_first_d;
      s1_last_q  <= s1_last_d;
    end
  end

  // num * sel with a 2-bit sel is a shift-and-add; the result never exceeds N-1.
  logic [LOG_N-1:0] prod;
  assign prod = (s1_sel_q[0] ? s1_num_q : '0)
              + (s1_sel_q[1] ? {s1_num_q[LOG_N-2:0], 1'b0} : '0);

  logic             en_q,    en_d;
  logic [LOG_N-1:0] addr_q,  addr_d;
  logic             unity_q, unity_d;
  logic             first_q, first_d;
  logic             last_q,  last_d;

  always_comb begin
    en_d    = s1_en_q;
    addr_d  = addr_q;
    unity_d = unity_q;
    first_d = first_q;
    last_d  = last_q;
    if (s1_en_q) begin
      addr_d  = prod;
      unity_d = (prod == '0);
      first_d = s1_first_q;
      last_d  = s1_last_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      en_q    <= 1'b0;
      addr_q  <= '0;
      unity_q <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      en_q    <= en_d;
      addr_q  <= addr_d;
      unity_q <= unity_d;
      first_q <= first_d;
      last_q  <= last_d;
    end
  end

  assign tw_en    = en_q;
  assign tw_addr  = addr_q;
  assign tw_unity = unity_q;
  assign tw_first = first_q;
  assign tw_last  = last_q;

endmodule

// File: tb/tb_twiddle_addr_gen.sv
// Bench for twiddle_addr_gen: LOG_N=6 with LOG_M=2..6 side by side, each
// checked every cycle against an arithmetic quadrant model plus directed spot checks.
module tb_twiddle_addr_gen;

  logic clk = 1'b0;
  logic rst;
  logic di_en;
  logic sync;

  int checks   = 0;
  int failures = 0;

  int cyc = 0;
  bit rst_hist [0:4095];

  bit cap_on = 1'b0;
  int cap6[$];
  int cap4[$];

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Quadrant q of the sub-transform multiplies the in-quadrant offset by 0,2,1,3.
  function automatic int quad_mult(input int idx, input int lm);
    int q;
    q = idx / ((1 << lm) / 4);
    case (q)
      0:       return 0;
      1:       return 2;
      2:       return 1;
      default: return 3;
    endcase
  endfunction

  function automatic int quad_off(input int idx, input int lm);
    return idx % ((1 << lm) / 4);
  endfunction

  function automatic int ref_addr(input int idx, input int lm);
    return quad_off(idx, lm) * (64 / (1 << lm)) * quad_mult(idx, lm);
  endfunction

  function automatic int ref_unity(input int idx, input int lm);
    return (quad_mult(idx, lm) == 0 || quad_off(idx, lm) == 0) ? 1 : 0;
  endfunction

  always @(posedge clk) begin
    if (cyc < 4096) rst_hist[cyc] <= rst;
    cyc <= cyc + 1;
  end

  for (genvar gi = 0; gi < 5; gi++) begin : g_dut
    localparam int LM = gi + 2;
    localparam int M  = 1 << LM;

    logic       tw_en;
    logic [5:0] tw_addr;
    logic       tw_unity;
    logic       tw_first;
    logic       tw_last;

    twiddle_addr_gen #(.LOG_N(6), .LOG_M(LM)) u_dut (
      .clock    (clk),
      .reset    (rst),
      .di_en    (di_en),
      .sync     (sync),
      .tw_en    (tw_en),
      .tw_addr  (tw_addr),
      .tw_unity (tw_unity),
      .tw_first (tw_first),
      .tw_last  (tw_last)
    );

    int m_n = 0;
    bit exp_en  [0:4095];
    int exp_idx [0:4095];

    always @(posedge clk) begin
      if (cyc < 4096) begin
        exp_en[cyc]  <= di_en && !rst;
        exp_idx[cyc] <= sync ? 0 : m_n;
      end
      if (rst) m_n <= 0;
      else if (di_en) m_n <= ((sync ? 0 : m_n) + 1) % M;
      else if (sync) m_n <= 0;
    end

    // Output seen now belongs to the sample taken two edges ago, unless reset hit since.
    always @(negedge clk) begin
      if (cyc >= 2 && cyc < 4096) begin
        check_eq($sformatf("m%0d_en", LM), int'(tw_en),
                 int'(exp_en[cyc-2] && !rst_hist[cyc-1]));
        if (tw_en && exp_en[cyc-2] && !rst_hist[cyc-1]) begin
          check_eq($sformatf("m%0d_addr_i%0d", LM, exp_idx[cyc-2]), int'(tw_addr),
                   ref_addr(exp_idx[cyc-2], LM));
          check_eq($sformatf("m%0d_unity_i%0d", LM, exp_idx[cyc-2]), int'(tw_unity),
                   ref_unity(exp_idx[cyc-2], LM));
          check_eq($sformatf("m%0d_first_i%0d", LM, exp_idx[cyc-2]), int'(tw_first),
                   int'(exp_idx[cyc-2] == 0));
          check_eq($sformatf("m%0d_last_i%0d", LM, exp_idx[cyc-2]), int'(tw_last),
                   int'(exp_idx[cyc-2] == M - 1));
        end
      end
    end
  end

  // Packed capture: addr | unity<<6 | first<<7 | last<<8.
  always @(negedge clk) begin
    if (cap_on) begin
      if (g_dut[4].tw_en)
        cap6.push_back(int'(g_dut[4].tw_addr) | (int'(g_dut[4].tw_unity) << 6) |
                       (int'(g_dut[4].tw_first) << 7) | (int'(g_dut[4].tw_last) << 8));
      if (g_dut[2].tw_en)
        cap4.push_back(int'(g_dut[2].tw_addr) | (int'(g_dut[2].tw_unity) << 6) |
                       (int'(g_dut[2].tw_first) << 7) | (int'(g_dut[2].tw_last) << 8));
    end
  end

  task automatic step(input bit r, input bit e, input bit s);
    rst   = r;
    di_en = e;
    sync  = s;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    repeat (3) step(1'b0, 1'b0, 1'b0);
  endtask

  int sent;
  bit e_bit;

  initial begin
    rst = 1'b1; di_en = 1'b0; sync = 1'b0;
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);

    check_eq("rst_en6",    int'(g_dut[4].tw_en),    0);
    check_eq("rst_addr6",  int'(g_dut[4].tw_addr),  0);
    check_eq("rst_unity6", int'(g_dut[4].tw_unity), 0);
    check_eq("rst_first6", int'(g_dut[4].tw_first), 0);
    check_eq("rst_last6",  int'(g_dut[4].tw_last),  0);
    check_eq("rst_en2",    int'(g_dut[0].tw_en),    0);

    // Continuous frame of 64 samples.
    cap6.delete(); cap4.delete(); cap_on = 1'b1;
    step(1'b0, 1'b1, 1'b0);
    check_eq("lat1_en", int'(g_dut[4].tw_en), 0);
    step(1'b0, 1'b1, 1'b0);
    check_eq("lat2_en", int'(g_dut[4].tw_en), 1);
    repeat (62) step(1'b0, 1'b1, 1'b0);
    drain();
    cap_on = 1'b0;
    check_eq("cont_cnt6", cap6.size(), 64);
    check_eq("cont_cnt4", cap4.size(), 64);
    if (cap6.size() == 64 && cap4.size() == 64) begin
      check_eq("n0_word",    cap6[0]  & 32'h1ff, 32'h0c0);
      check_eq("n15_addr",   cap6[15] & 32'h3f, 0);
      check_eq("n17_addr",   cap6[17] & 32'h3f, 2);
      check_eq("n31_addr",   cap6[31] & 32'h3f, 30);
      check_eq("n47_addr",   cap6[47] & 32'h3f, 15);
      check_eq("n63_addr",   cap6[63] & 32'h3f, 45);
      check_eq("n63_last",   (cap6[63] >> 8) & 1, 1);
      check_eq("m4_n5",      cap4[5]  & 32'h3f, 8);
      check_eq("m4_n9",      cap4[9]  & 32'h3f, 4);
      check_eq("m4_n15",     cap4[15] & 32'h3f, 36);
      check_eq("m4_n12_u",   cap4[12] & 32'h7f, 32'h40);
      check_eq("m4_f2_n15",  cap4[31] & 32'h1ff, 36 | (1 << 8));
      check_eq("m4_f2_n0",   cap4[16] & 32'h1ff, 32'h0c0);
    end

    // 128 samples with random gaps.
    sent = 0;
    while (sent < 128) begin
      e_bit = ($urandom_range(0, 2) != 0);
      step(1'b0, e_bit, 1'b0);
      if (e_bit) sent++;
    end
    drain();

    // sync with a sample at n=20.
    step(1'b1, 1'b0, 1'b0);
    cap6.delete(); cap_on = 1'b1;
    repeat (20) step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    repeat (2) step(1'b0, 1'b1, 1'b0);
    drain();
    cap_on = 1'b0;
    check_eq("sync_cnt", cap6.size(), 23);
    if (cap6.size() == 23) begin
      check_eq("sync_word", cap6[20] & 32'h1ff, 32'h0c0);
      check_eq("sync_next", cap6[21] & 32'h1ff, 32'h040);
    end

    // reset for one cycle at n=40 while samples are in flight.
    step(1'b1, 1'b0, 1'b0);
    repeat (40) step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check_eq("midrst_en6", int'(g_dut[4].tw_en), 0);
    check_eq("midrst_en4", int'(g_dut[2].tw_en), 0);
    step(1'b0, 1'b0, 1'b0);
    check_eq("midrst_en6b", int'(g_dut[4].tw_en), 0);
    cap6.delete(); cap_on = 1'b1;
    repeat (2) step(1'b0, 1'b1, 1'b0);
    drain();
    cap_on = 1'b0;
    check_eq("post_rst_cnt", cap6.size(), 2);
    if (cap6.size() == 2)
      check_eq("post_rst_word", cap6[0] & 32'h1ff, 32'h0c0);

    // Random mix of enables, syncs and occasional resets.
    repeat (1000)
      step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
